// File: rtl/rob_pkg.sv
// Shared types for the multi-port reorder buffer: dispatch kinds, the
// per-entry record, and the redirect-PC helper used on a mispredict.
package rob_pkg;

  typedef enum logic [2:0] {
    INT    = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    BRANCH = 3'd5,
    JUMP   = 3'd6
  } dispatch_type;

  // Width of the stored result; rob_mp casts to/from its DATA_W.
  localparam int ROB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    dispatch_type          dtype;
    logic [4:0]            rd;
    logic [31:0]           pc;
    logic [31:0]           br_target;
    logic                  br_pred;
    logic                  taken;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

  // Correct-path PC for a resolved branch: target if taken, else fall-through.
  function automatic logic [31:0] redirect_pc(input rob_entry_t e);
    return e.taken ? e.br_target : (e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/rob_mp_ptr.sv
// Head/tail pointers and occupancy counter for the ROB. Pointers wrap
// naturally because DEPTH is a power of two; flush returns everything to 0.
module rob_mp_ptr
  import rob_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int TAG_W = $clog2(DEPTH),
  localparam int CNT_W = TAG_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [1:0]       pop_cnt,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [CNT_W-1:0] count
);

  // Pointer/count state: clear on reset or flush, else advance by push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + TAG_W'(pop_cnt);
      tail  <= tail + TAG_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

endmodule

// File: rtl/rob_mp.sv
// Reorder buffer with multiple CDB completion ports, operand lookup with
// same-cycle CDB bypass, up to two in-order retires per cycle and a
// branch-mispredict flush.
module rob_mp
  import rob_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int N_CDB    = 2,
  parameter  int RETIRE_W = 2,
  parameter  int DATA_W   = 32,
  localparam int TAG_W    = $clog2(DEPTH),
  localparam int CNT_W    = TAG_W + 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      disp_valid,
  input  logic [2:0]                disp_type,
  input  logic [4:0]                disp_rd,
  input  logic [31:0]               disp_pc,
  input  logic [31:0]               disp_br_target,
  input  logic                      disp_br_pred,
  output logic                      disp_ready,
  output logic [TAG_W-1:0]          disp_tag,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]   cdb_data,
  input  logic [N_CDB-1:0]          cdb_br_taken,
  input  logic [TAG_W-1:0]          rs1_tag,
  input  logic [TAG_W-1:0]          rs2_tag,
  output logic                      rs1_ready,
  output logic                      rs2_ready,
  output logic [DATA_W-1:0]         rs1_data,
  output logic [DATA_W-1:0]         rs2_data,
  output logic [RETIRE_W-1:0]       ret_valid,
  output logic [RETIRE_W*TAG_W-1:0] ret_tag,
  output logic [RETIRE_W*5-1:0]     ret_rd,
  output logic [RETIRE_W*DATA_W-1:0] ret_data,
  output logic [RETIRE_W*3-1:0]     ret_type,
  output logic [RETIRE_W*32-1:0]    ret_pc,
  output logic                      flush,
  output logic [31:0]               flush_target,
  output logic [CNT_W-1:0]          count
);

  rob_entry_t       entries [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] head1;
  logic             push;
  logic [1:0]       pop_cnt;
  logic [1:0]       slot_go;
  logic [TAG_W-1:0] slot_tag [2];
  rob_entry_t       slot_ent [2];

  rob_mp_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush   (flush),
    .push    (push),
    .pop_cnt (pop_cnt),
    .head    (head),
    .tail    (tail),
    .count   (count)
  );

  // Dispatch handshake: allocate the tail slot; JUMPs never occupy an entry.
  always_comb begin
    disp_ready = (count < CNT_W'(DEPTH)) && !flush;
    disp_tag   = tail;
    push       = disp_valid && disp_ready && (dispatch_type'(disp_type) != JUMP);
  end

  // Retire decision for the two oldest entries plus mispredict detection.
  always_comb begin
    head1       = head + TAG_W'(1'b1);
    slot_tag[0] = head;
    slot_tag[1] = head1;
    slot_ent[0] = entries[head];
    slot_ent[1] = entries[head1];
    slot_go[0]  = slot_ent[0].valid && slot_ent[0].done;
    // A branch in slot 0 retires alone so a flush never drags a younger op out.
    if (RETIRE_W == 2) begin
      slot_go[1] = slot_go[0] && slot_ent[1].valid && slot_ent[1].done &&
                   (slot_ent[0].dtype != BRANCH);
    end else begin
      slot_go[1] = 1'b0;
    end
    flush = slot_go[0] && (slot_ent[0].dtype == BRANCH) &&
            (slot_ent[0].taken != slot_ent[0].br_pred);
    if (flush) begin
      flush_target = redirect_pc(slot_ent[0]);
    end else begin
      flush_target = 32'd0;
    end
    pop_cnt = {1'b0, slot_go[0]} + {1'b0, slot_go[1]};
  end

  // Retire port drive; idle slots read as zero.
  always_comb begin
    ret_valid = '0;
    ret_tag   = '0;
    ret_rd    = '0;
    ret_data  = '0;
    ret_type  = '0;
    ret_pc    = '0;
    for (int s = 0; s < RETIRE_W; s++) begin
      if (slot_go[s]) begin
        ret_valid[s]                   = 1'b1;
        ret_tag[s*TAG_W +: TAG_W]      = slot_tag[s];
        ret_rd[s*5 +: 5]               = slot_ent[s].rd;
        ret_data[s*DATA_W +: DATA_W]   = DATA_W'(slot_ent[s].data);
        ret_type[s*3 +: 3]             = slot_ent[s].dtype;
        ret_pc[s*32 +: 32]             = slot_ent[s].pc;
      end else begin
        ret_valid[s] = 1'b0;
      end
    end
  end

  // Operand lookup: stored result, overridden by a same-cycle CDB hit
  // (later ports are checked last so the highest matching port wins).
  always_comb begin
    rs1_ready = entries[rs1_tag].valid && entries[rs1_tag].done;
    rs1_data  = DATA_W'(entries[rs1_tag].data);
    rs2_ready = entries[rs2_tag].valid && entries[rs2_tag].done;
    rs2_data  = DATA_W'(entries[rs2_tag].data);
    for (int p = 0; p < N_CDB; p++) begin
      rs1_ready = rs1_ready || (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rs1_tag));
      rs1_data  = (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rs1_tag)) ?
                  cdb_data[p*DATA_W +: DATA_W] : rs1_data;
      rs2_ready = rs2_ready || (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rs2_tag));
      rs2_data  = (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rs2_tag)) ?
                  cdb_data[p*DATA_W +: DATA_W] : rs2_data;
    end
  end

  // Entry array: reset/flush wipe, then completions, retire clears, dispatch write.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int p = 0; p < N_CDB; p++) begin
        if (cdb_valid[p] && entries[cdb_tag[p*TAG_W +: TAG_W]].valid) begin
          entries[cdb_tag[p*TAG_W +: TAG_W]].done  <= 1'b1;
          entries[cdb_tag[p*TAG_W +: TAG_W]].data  <= ROB_DATA_W'(cdb_data[p*DATA_W +: DATA_W]);
          entries[cdb_tag[p*TAG_W +: TAG_W]].taken <= cdb_br_taken[p];
        end
      end
      if (slot_go[0]) begin
        entries[head] <= '0;
      end
      if (slot_go[1]) begin
        entries[head1] <= '0;
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, dtype: dispatch_type'(disp_type),
                           rd: disp_rd, pc: disp_pc, br_target: disp_br_target,
                           br_pred: disp_br_pred, taken: 1'b0, data: '0};
      end
    end
  end

endmodule

// File: tb/tb_rob_mp.sv
// Directed + randomized bench for rob_mp. A queue of in-flight ops (oldest
// first) is the reference; every cycle all outputs are compared against it.
module tb_rob_mp;
  import rob_pkg::*;

  localparam int DEPTH = 16, N_CDB = 2, RETIRE_W = 2, DATA_W = 32;
  localparam int TAG_W = 4, CNT_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst;
  logic disp_valid, disp_br_pred, disp_ready;
  logic [2:0] disp_type;
  logic [4:0] disp_rd;
  logic [31:0] disp_pc, disp_br_target;
  logic [TAG_W-1:0] disp_tag, rs1_tag, rs2_tag;
  logic [1:0] cdb_valid, cdb_br_taken;
  logic [7:0] cdb_tag;
  logic [63:0] cdb_data;
  logic rs1_ready, rs2_ready;
  logic [31:0] rs1_data, rs2_data;
  logic [1:0] ret_valid;
  logic [7:0] ret_tag;
  logic [9:0] ret_rd;
  logic [63:0] ret_data;
  logic [5:0] ret_type;
  logic [63:0] ret_pc;
  logic flush;
  logic [31:0] flush_target;
  logic [CNT_W-1:0] count;

  rob_mp #(.DEPTH(DEPTH), .N_CDB(N_CDB), .RETIRE_W(RETIRE_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .disp_valid(disp_valid), .disp_type(disp_type), .disp_rd(disp_rd), .disp_pc(disp_pc),
    .disp_br_target(disp_br_target), .disp_br_pred(disp_br_pred),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_br_taken(cdb_br_taken),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_rd(ret_rd), .ret_data(ret_data),
    .ret_type(ret_type), .ret_pc(ret_pc),
    .flush(flush), .flush_target(flush_target), .count(count)
  );

  typedef struct {
    int          tag;
    logic [2:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
    logic        done;
    logic        taken;
    logic [31:0] data;
  } ment_t;

  ment_t mq[$];
  int    m_tail = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [3:0] t);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].tag == int'(t)) return i;
    end
    return -1;
  endfunction

  task automatic head_status(output bit r0, output bit r1, output bit fl, output logic [31:0] ft);
    r0 = (mq.size() > 0) && mq[0].done;
    r1 = r0 && (mq.size() > 1) && mq[1].done && (mq[0].typ != BRANCH);
    fl = r0 && (mq[0].typ == BRANCH) && (mq[0].taken != mq[0].pred);
    ft = 32'd0;
    if (fl) ft = mq[0].taken ? mq[0].tgt : mq[0].pc + 32'd4;
  endtask

  task automatic rs_exp(input logic [3:0] t, output logic rdy, output logic [31:0] d);
    int idx;
    idx = find(t);
    rdy = 1'b0;
    d   = 32'd0;
    if (idx >= 0) begin
      rdy = mq[idx].done;
      d   = mq[idx].data;
    end
    for (int p = 0; p < N_CDB; p++) begin
      if (cdb_valid[p] && (cdb_tag[p*4 +: 4] == t)) begin
        rdy = 1'b1;
        d   = cdb_data[p*32 +: 32];
      end
    end
  endtask

  // Compare every output against the model, away from the clock edge.
  task automatic settle();
    bit r0, r1, fl;
    logic [31:0] ft, d1, d2;
    logic rr1, rr2;
    logic [1:0] ev;
    logic [7:0] etag;
    logic [9:0] erd;
    logic [63:0] edata, epc;
    logic [5:0] etyp;
    #1;
    head_status(r0, r1, fl, ft);
    ev = {r1, r0};
    etag = '0; erd = '0; edata = '0; epc = '0; etyp = '0;
    for (int s = 0; s < 2; s++) begin
      if (ev[s]) begin
        etag[s*4 +: 4]    = 4'(mq[s].tag);
        erd[s*5 +: 5]     = mq[s].rd;
        edata[s*32 +: 32] = mq[s].data;
        etyp[s*3 +: 3]    = mq[s].typ;
        epc[s*32 +: 32]   = mq[s].pc;
      end
    end
    rs_exp(rs1_tag, rr1, d1);
    rs_exp(rs2_tag, rr2, d2);
    chk("ret_valid", 64'(ret_valid), 64'(ev));
    chk("ret_tag", 64'(ret_tag), 64'(etag));
    chk("ret_rd", 64'(ret_rd), 64'(erd));
    chk("ret_data", ret_data, edata);
    chk("ret_type", 64'(ret_type), 64'(etyp));
    chk("ret_pc", ret_pc, epc);
    chk("flush", 64'(flush), 64'(fl));
    chk("flush_target", 64'(flush_target), 64'(ft));
    chk("count", 64'(count), 64'(mq.size()));
    chk("disp_ready", 64'(disp_ready), 64'((mq.size() < DEPTH) && !fl));
    chk("disp_tag", 64'(disp_tag), 64'(m_tail));
    chk("rs1_ready", 64'(rs1_ready), 64'(rr1));
    chk("rs1_data", 64'(rs1_data), 64'(d1));
    chk("rs2_ready", 64'(rs2_ready), 64'(rr2));
    chk("rs2_data", 64'(rs2_data), 64'(d2));
  endtask

  // Clock edge: apply the rules of the buffer to the model using current inputs.
  task automatic adv();
    bit r0, r1, fl, acc;
    logic [31:0] ft;
    int idx;
    ment_t e;
    @(posedge clk);
    head_status(r0, r1, fl, ft);
    if (i_rst || fl) begin
      mq.delete();
      m_tail = 0;
    end else begin
      acc = disp_valid && (mq.size() < DEPTH) && (disp_type != JUMP);
      for (int p = 0; p < N_CDB; p++) begin
        if (cdb_valid[p]) begin
          idx = find(cdb_tag[p*4 +: 4]);
          if (idx >= 0) begin
            e = mq[idx];
            e.done = 1'b1;
            e.data = cdb_data[p*32 +: 32];
            e.taken = cdb_br_taken[p];
            mq[idx] = e;
          end
        end
      end
      if (r0) void'(mq.pop_front());
      if (r1) void'(mq.pop_front());
      if (acc) begin
        e.tag = m_tail; e.typ = disp_type; e.rd = disp_rd; e.pc = disp_pc;
        e.tgt = disp_br_target; e.pred = disp_br_pred;
        e.done = 1'b0; e.taken = 1'b0; e.data = 32'd0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_type = INT; disp_rd = 5'd0; disp_pc = 32'd0;
    disp_br_target = 32'd0; disp_br_pred = 1'b0;
    cdb_valid = 2'b00; cdb_tag = 8'd0; cdb_data = 64'd0; cdb_br_taken = 2'b00;
  endtask

  task automatic dispatch(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic [4:0] rd);
    disp_valid = 1'b1; disp_type = t; disp_pc = pc; disp_br_target = tgt;
    disp_br_pred = pred; disp_rd = rd;
  endtask

  task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] d, input logic tk);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*4 +: 4] = tag;
    cdb_data[p*32 +: 32] = d;
    cdb_br_taken[p] = tk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [2:0] ty;
    idle();
    i_rst = 1'b1; rs1_tag = 4'd0; rs2_tag = 4'd0;
    @(negedge clk);
    adv(); adv();
    i_rst = 1'b0;
    settle();
    chk("reset_ready", 64'(disp_ready), 64'd1);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ret", 64'(ret_valid), 64'd0);
    chk("reset_flush", 64'(flush), 64'd0);
    adv();

    // Fill all 16 entries; the 17th is dropped.
    for (int i = 0; i < 16; i++) begin
      dispatch(INT, 32'h1000 + 32'(4 * i), 32'd0, 1'b0, 5'(i));
      settle();
      chk("fill_tag", 64'(disp_tag), 64'(i));
      adv();
    end
    dispatch(INT, 32'h2000, 32'd0, 1'b0, 5'd1);
    settle();
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(disp_ready), 64'd0);
    adv();
    idle();
    settle();
    chk("drop_count", 64'(count), 64'd16);
    chk("drop_tag", 64'(disp_tag), 64'd0);
    adv();

    // Tags 1 and 0 complete together; both retire next cycle in order.
    cdb(0, 4'd1, 32'h11, 1'b0);
    cdb(1, 4'd0, 32'h22, 1'b0);
    settle(); adv(); idle();
    settle();
    chk("pair_valid", 64'(ret_valid), 64'h3);
    chk("pair_tag", 64'(ret_tag), 64'h10);
    chk("pair_data", ret_data, 64'h0000_0011_0000_0022);
    adv();
    settle();
    chk("pair_count", 64'(count), 64'd14);
    adv();

    // Reset with a retire pending: nothing retires or flushes afterwards.
    cdb(0, 4'd2, 32'h33, 1'b0);
    settle(); adv(); idle();
    i_rst = 1'b1;
    settle();
    chk("pre_rst_ret", 64'(ret_valid), 64'h1);
    adv();
    i_rst = 1'b0;
    settle();
    chk("post_rst_ret", 64'(ret_valid), 64'd0);
    chk("post_rst_flush", 64'(flush), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);
    adv();

    // Mispredicted branch at head: flush to 0x100, younger op not retired.
    dispatch(BRANCH, 32'h40, 32'h100, 1'b0, 5'd3);
    settle(); adv();
    dispatch(INT, 32'h44, 32'd0, 1'b0, 5'd4);
    settle(); adv(); idle();
    cdb(0, 4'd1, 32'h5, 1'b0);
    cdb(1, 4'd0, 32'h0, 1'b1);
    settle(); adv(); idle();
    settle();
    chk("br_flush", 64'(flush), 64'd1);
    chk("br_target", 64'(flush_target), 64'h100);
    chk("br_slot1", 64'(ret_valid), 64'h1);
    adv();
    settle();
    chk("br_count", 64'(count), 64'd0);
    adv();

    // Operand bypass and port priority.
    for (int i = 0; i < 4; i++) begin
      dispatch(MULT, 32'h200 + 32'(4 * i), 32'd0, 1'b0, 5'(i + 8));
      settle(); adv();
    end
    idle();
    rs1_tag = 4'd3; rs2_tag = 4'd2;
    cdb(0, 4'd3, 32'hABCD, 1'b0);
    settle();
    chk("byp_ready", 64'(rs1_ready), 64'd1);
    chk("byp_data", 64'(rs1_data), 64'hABCD);
    chk("byp_rs2_ready", 64'(rs2_ready), 64'd0);
    adv(); idle();
    cdb(0, 4'd2, 32'h1, 1'b0);
    cdb(1, 4'd2, 32'h2, 1'b0);
    settle();
    chk("prio_byp_data", 64'(rs2_data), 64'h2);
    adv(); idle();
    settle();
    chk("stored_rs1", 64'(rs1_data), 64'hABCD);
    chk("prio_stored", 64'(rs2_data), 64'h2);
    adv();

    // JUMP consumes nothing.
    dispatch(JUMP, 32'h300, 32'h400, 1'b0, 5'd1);
    settle();
    chk("jump_tag", 64'(disp_tag), 64'd4);
    adv(); idle();
    settle();
    chk("jump_count", 64'(count), 64'd4);
    chk("jump_tag_after", 64'(disp_tag), 64'd4);
    adv();
    i_rst = 1'b1;
    settle(); adv();
    i_rst = 1'b0;

    // Steady dispatch/retire pairs across the wrap point.
    dispatch(INT, 32'h500, 32'd0, 1'b0, 5'd1);
    settle(); adv();
    dispatch(INT, 32'h504, 32'd0, 1'b0, 5'd2);
    cdb(0, 4'd0, 32'h70, 1'b0);
    settle(); adv();
    for (int k = 0; k < 40; k++) begin
      idle();
      dispatch(LOAD, 32'h600 + 32'(4 * k), 32'd0, 1'b0, 5'(k));
      cdb(0, 4'((k + 1) % 16), 32'(k + 100), 1'b0);
      settle();
      chk("wrap_tag", 64'(disp_tag), 64'((k + 2) % 16));
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_ret_tag", 64'(ret_tag), 64'(k % 16));
      adv();
    end
    idle();

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 11);
        ty = (r > 6) ? 3'(INT) : 3'(r);
        dispatch(ty, $urandom, $urandom, 1'($urandom), 5'($urandom));
      end
      for (int p = 0; p < N_CDB; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ((mq.size() > 0) && ($urandom_range(0, 3) != 0))
            cdb(p, 4'(mq[$urandom_range(0, mq.size() - 1)].tag), $urandom, 1'($urandom));
          else
            cdb(p, 4'($urandom), $urandom, 1'($urandom));
        end
      end
      rs1_tag = ($urandom_range(0, 3) == 0) ? cdb_tag[3:0] : 4'($urandom);
      rs2_tag = ($urandom_range(0, 3) == 0) ? cdb_tag[7:4] : 4'($urandom);
      i_rst = ($urandom_range(0, 199) == 0);
      settle();
      adv();
    end
    i_rst = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_mp.md
ROB_MP -- requirements
Module: rob_mp

Interface
REQ-001 The block SHALL use parameter DEPTH, default 16, meaning ROB entry count, a power of two from 4 to 64.
REQ-002 The block SHALL use parameter N_CDB, default 2, meaning the number of completion (CDB) ports.
REQ-003 The block SHALL use parameter RETIRE_W, default 2, meaning maximum retires per cycle, 1 or 2.
REQ-004 The block SHALL use parameter DATA_W, default 32, meaning result width; derived TAG_W=$clog2(DEPTH), CNT_W=TAG_W+1.
REQ-005 The block SHALL have one clock with synchronous, active-high reset; ports in REQ-006 to REQ-013.
REQ-006 The block SHALL have these clock/reset ports: i_clk in 1 system clock; i_rst in 1 synchronous active-high reset.
REQ-007 The block SHALL have these dispatch ports: disp_valid in 1; disp_type in 3 (dispatch_type); disp_rd in 5; disp_pc in 32; disp_br_target in 32; disp_br_pred in 1; disp_ready out 1; disp_tag out TAG_W (tag allocated this cycle).
REQ-008 The block SHALL have these completion ports: cdb_valid in N_CDB; cdb_tag in N_CDB*TAG_W; cdb_data in N_CDB*DATA_W; cdb_br_taken in N_CDB.
REQ-009 The block SHALL have these operand lookup ports: rs1_tag, rs2_tag in TAG_W; rs1_ready, rs2_ready out 1; rs1_data, rs2_data out DATA_W.
REQ-010 The block SHALL have these retire ports: ret_valid out RETIRE_W; ret_tag out RETIRE_W*TAG_W; ret_rd out RETIRE_W*5; ret_data out RETIRE_W*DATA_W; ret_type out RETIRE_W*3; ret_pc out RETIRE_W*32.
REQ-011 The block SHALL have these flush ports: flush out 1, asserted for a branch mispredict; flush_target out 32, the redirect PC.
REQ-012 The block SHALL have this status port: count out CNT_W, the number of occupied entries.
REQ-013 The block SHALL drive all outputs from the registered entry state, with the combinational paths of REQ-017 and REQ-019 to REQ-022.

Function
REQ-014 The block SHALL allocate disp_tag equal to the tail index; disp_ready SHALL equal (count<DEPTH) and not flush.
REQ-015 The block SHALL accept a dispatch when disp_valid and disp_ready are high and disp_type is not JUMP. An accepted dispatch SHALL write the entry at the next edge with valid=1, done=0, data=0, taken=0 and the dispatch fields, and SHALL advance the tail modulo DEPTH.
REQ-016 The block SHALL ignore a JUMP dispatch: no allocation and no tail movement.
REQ-017 For each CDB port with cdb_valid high and a valid target entry, the block SHALL set done=1, data and taken at the next edge. A CDB write to an invalid entry SHALL be ignored. Two ports addressing the same tag SHALL resolve with the higher port index winning.
REQ-018 The block SHALL compute rsN_ready = entry valid and done, with rsN_data = entry data.
REQ-019 A same-cycle CDB hit on rsN_tag SHALL bypass the entry state, giving rsN_ready=1 and rsN_data=cdb_data; the highest matching port wins.
REQ-020 Retire slot 0 SHALL assert when the head entry is valid and done.
REQ-021 Retire slot 1, when RETIRE_W=2, SHALL assert only if slot 0 retires, head+1 is valid and done, and slot 0 is not BRANCH.
REQ-022 The block SHALL assert flush for a retiring BRANCH whose taken differs from its prediction. flush_target SHALL be br_target if taken, else pc+4 (32-bit wrap).
REQ-023 In a flush cycle the block SHALL accept no dispatch. At the next edge it SHALL clear every valid, set head=tail=0 and count=0.
REQ-024 Retired entries SHALL be cleared to valid=0 at the next edge, and the head SHALL advance by the retire count modulo DEPTH.
REQ-025 The next count SHALL equal count + accepted dispatch − retires, covering full+retire, empty+dispatch and wrap-around of head and tail.
REQ-026 Retire slot outputs SHALL be 0 when the corresponding ret_valid bit is low.

Reset
REQ-027 When i_rst is high at an edge, the block SHALL clear all valid and done bits and set head=tail=0 and count=0. Following that reset, disp_ready=1 and all other outputs are 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries with no retire or flush in the following cycle.

Structure
REQ-029 Package rob_pkg SHALL hold the dispatch_type enum (INT, MULT, DIV, LOAD, STORE, BRANCH, JUMP) and the rob_entry_t struct (valid, done, type, rd, pc, br_target, br_pred, taken, data).
REQ-030 Sub-module rob_mp_ptr SHALL implement the head/tail pointers and the count with wrap and flush clear; the entry array stays in rob_mp.

Verification
REQ-031 Bench SHALL check: reset, then 16 dispatches with DEPTH=16 -> tags 0..15, count=16, disp_ready=0, and the 17th dispatch dropped.
REQ-032 Bench SHALL check: CDB completes tags 1 and 0 in the same cycle on ports 0 and 1 -> next cycle ret_valid=2'b11, with ret_tag 0 then 1.
REQ-033 Bench SHALL check: head is a BRANCH with pred=0 and completes taken=1 with target 0x100 -> flush=1, flush_target=0x100, slot 1 not retired, count=0 the next cycle.
REQ-034 Bench SHALL check: rs1_tag=3 while CDB writes tag 3 with data 0xABCD -> rs1_ready=1 and rs1_data=0xABCD in the same cycle.
REQ-035 Bench SHALL check: a JUMP dispatch -> no tag consumed and count unchanged.
REQ-036 Bench SHALL check: wrap-around, with 40 dispatch/retire pairs at DEPTH=16 -> tags wrap 15->0 and count stays constant.
